dmem_arbiter: RTL and testbench

//   Shares the single-port dmem among NUM_CH requesters (ch0 = processor; others e.g. VGA board

---
 rtl/dmem_arb_pkg.sv | 25 ++
 rtl/dmem_arbiter_if.sv | 39 +++
 rtl/dmem_arbiter_rr_pick.sv | 30 +++
 rtl/dmem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
//   Shared constants and types for the dmem arbiter slice.
//   - ARB_ADDR_W / ARB_DATA_W : default dmem geometry (matches imem/dmem)
//   - ARB_NUM_CH / ARB_MAX_BURST : default requester count and burst limit
//   - arb_idx_w()  : channel-index width, never narrower than one bit
//   - arb_ch_idx_t : channel index for the default channel count
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

    localparam int ARB_ADDR_W    = 12;
    localparam int ARB_DATA_W    = 32;
    localparam int ARB_NUM_CH    = 2;
    localparam int ARB_MAX_BURST = 4;

    // $clog2(1) is 0, which would give a zero-width index for a single channel
    function automatic int arb_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ARB_CH_IDX_W = arb_idx_w(ARB_NUM_CH);

    typedef logic [ARB_CH_IDX_W-1:0] arb_ch_idx_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
//   Bundles the requester-side handshake and the dmem port of the arbiter.
//   Per-channel buses are packed [NUM_CH-1:0][W-1:0], so channel k occupies
//   bits [k*W +: W] exactly like a flattened vector.
//   Requester side : req, lock, wren_ch, addr_ch, wdata_ch -> gnt, rvalid, rdata
//   dmem side      : mem_addr, mem_data, mem_wren -> mem_q
//   Modports: slave (the arbiter), master (requesters + dmem model).
// -----------------------------------------------------------------------------
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int NUM_CH = ARB_NUM_CH,
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
);
    logic [NUM_CH-1:0]             req;
    logic [NUM_CH-1:0]             lock;
    logic [NUM_CH-1:0]             wren_ch;
    logic [NUM_CH-1:0][ADDR_W-1:0] addr_ch;
    logic [NUM_CH-1:0][DATA_W-1:0] wdata_ch;
    logic [NUM_CH-1:0]             gnt;
    logic [NUM_CH-1:0]             rvalid;
    logic [DATA_W-1:0]             rdata;
    logic [ADDR_W-1:0]             mem_addr;
    logic [DATA_W-1:0]             mem_data;
    logic                          mem_wren;
    logic [DATA_W-1:0]             mem_q;

    modport slave (
        input  req, lock, wren_ch, addr_ch, wdata_ch, mem_q,
        output gnt, rvalid, rdata, mem_addr, mem_data, mem_wren
    );

    modport master (
        output req, lock, wren_ch, addr_ch, wdata_ch, mem_q,
        input  gnt, rvalid, rdata, mem_addr, mem_data, mem_wren
    );
endinterface

// File: rtl/dmem_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational one-hot round-robin picker: grants the first requesting
//   channel found scanning i_ptr, i_ptr+1, ... wrapping modulo NUM_CH.
//   i_req [NUM_CH]  : requests
//   i_ptr [IDX_W]   : highest-priority channel this cycle (< NUM_CH)
//   o_gnt [NUM_CH]  : one-hot grant, zero when nothing requests
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = 1
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [IDX_W-1:0]  i_ptr,
    output logic [NUM_CH-1:0] o_gnt
);

    always_comb begin
        int idx;
        o_gnt = '0;
        idx   = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(i_ptr) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            // first hit in scan order wins; later hits are ignored
            if (o_gnt == '0 && i_req[idx]) o_gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares the single-port dmem among NUM_CH requesters (ch0 = processor).
//   Grants at most one channel per cycle, muxes its access onto the dmem
//   port combinationally and returns read data one cycle later with a
//   per-channel rvalid strobe. dmem itself samples on the falling edge.
//
//   Ports
//     clock      : master clock, rising edge
//     reset      : synchronous, active-high
//     bus.slave  : req/lock/wren_ch/addr_ch/wdata_ch in, gnt/rvalid/rdata out,
//                  mem_addr/mem_data/mem_wren out to dmem, mem_q in from dmem
//
//   Configuration macro: DMEM_ARB_CH0_PRIORITY_EN
//     defined   : ch0 wins whenever it requests; ptr/owner/burst state only
//                 tracks ch1..NUM_CH-1 and a ch0 grant leaves it untouched.
//     undefined : round-robin plus lock bursts over all channels.
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int NUM_CH    = ARB_NUM_CH,
    parameter int ADDR_W    = ARB_ADDR_W,
    parameter int DATA_W    = ARB_DATA_W,
    parameter int MAX_BURST = ARB_MAX_BURST
) (
    input  logic           clock,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

    localparam int IDX_W = arb_idx_w(NUM_CH);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    // arbitration state
    logic [IDX_W-1:0]  r_ptr;
    logic [IDX_W-1:0]  r_owner;
    logic [CNT_W-1:0]  r_burst_cnt;
    // read-return tracker
    logic              r_rd_pend;
    logic [IDX_W-1:0]  r_rd_ch;

    logic [NUM_CH-1:0] w_rr_req;
    logic [NUM_CH-1:0] w_rr_gnt;
    logic [NUM_CH-1:0] w_gnt;
    logic [IDX_W-1:0]  w_gnt_idx;
    logic              w_any_gnt;
    logic              w_upd_arb;
    logic              w_owner_hold;
    logic              w_burst_more;
    logic [IDX_W-1:0]  w_ptr_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;

    // ---------------------------------------------------------------------
    // Round-robin candidates
    // ---------------------------------------------------------------------
    always_comb begin
        w_rr_req = bus.req;
`ifdef DMEM_ARB_CH0_PRIORITY_EN
        // ch0 is served ahead of the rotation, so keep it out of it
        w_rr_req[0] = 1'b0;
`endif
    end

    rr_pick #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_rr_pick (
        .i_req  (w_rr_req),
        .i_ptr  (r_ptr),
        .o_gnt  (w_rr_gnt)
    );

    // ---------------------------------------------------------------------
    // Grant selection
    // ---------------------------------------------------------------------
    assign w_burst_more = (r_burst_cnt < CNT_W'(MAX_BURST));
    assign w_owner_hold = bus.req[r_owner] & bus.lock[r_owner] & w_burst_more;

    always_comb begin
        w_gnt = '0;
        if (reset) begin
            w_gnt = '0;
        end
`ifdef DMEM_ARB_CH0_PRIORITY_EN
        else if (bus.req[0]) begin
            w_gnt[0] = 1'b1;
        end
`endif
        else if (w_owner_hold) begin
            w_gnt[r_owner] = 1'b1;
        end
        else begin
            w_gnt = w_rr_gnt;
        end
    end

    always_comb begin
        w_gnt_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_gnt[i]) w_gnt_idx = IDX_W'(i);
        end
    end

    assign w_any_gnt = |w_gnt;

`ifdef DMEM_ARB_CH0_PRIORITY_EN
    // a ch0 grant must not disturb the rotation among the other channels
    assign w_upd_arb = w_any_gnt & ~w_gnt[0];
`else
    assign w_upd_arb = w_any_gnt;
`endif

    assign w_ptr_nxt = (w_gnt_idx == IDX_W'(NUM_CH - 1)) ? '0 : w_gnt_idx + IDX_W'(1);

    // continuing a burst counts up; a fresh owner, no lock, or an exhausted
    // burst that was re-won by a sole requester all restart at 1
    assign w_cnt_nxt = (w_gnt_idx == r_owner && bus.lock[w_gnt_idx] && w_burst_more)
                     ? r_burst_cnt + CNT_W'(1) : CNT_W'(1);

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr       <= '0;
            r_owner     <= '0;
            r_burst_cnt <= '0;
            r_rd_pend   <= 1'b0;
            r_rd_ch     <= '0;
        end else begin
            if (w_upd_arb) begin
                r_ptr       <= w_ptr_nxt;
                r_owner     <= w_gnt_idx;
                r_burst_cnt <= w_cnt_nxt;
            end else if (!w_any_gnt) begin
                r_burst_cnt <= '0;
            end
            r_rd_pend <= w_any_gnt & ~bus.wren_ch[w_gnt_idx];
            r_rd_ch   <= w_gnt_idx;
        end
    end

    // ---------------------------------------------------------------------
    // dmem port and read return
    // ---------------------------------------------------------------------
    assign bus.gnt      = w_gnt;
    assign bus.mem_addr = w_any_gnt ? bus.addr_ch[w_gnt_idx]  : '0;
    assign bus.mem_data = w_any_gnt ? bus.wdata_ch[w_gnt_idx] : '0;
    assign bus.mem_wren = w_any_gnt & bus.wren_ch[w_gnt_idx];

    // dmem latched the address on the falling edge of the grant cycle, so
    // mem_q already holds the data for the pending read
    assign bus.rdata = bus.mem_q;

    always_comb begin
        bus.rvalid = '0;
        // reset drops a pending return in the same cycle it is asserted
        if (r_rd_pend && !reset) bus.rvalid[r_rd_ch] = 1'b1;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int NUM_CH = 2;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    logic clock;
    logic reset;
    int   n_chk;
    int   n_fail;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    dmem_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_arbiter #(
        .NUM_CH    (NUM_CH),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MAX_BURST (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // dmem model: samples address/write on the falling edge; preloaded in reset
    always @(negedge clock) begin
        if (reset) begin
            mem[12'h010] <= 32'hDEADBEEF;
        end else if (bus.mem_wren) begin
            mem[bus.mem_addr] <= bus.mem_data;
        end
        bus.mem_q <= mem[bus.mem_addr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [NUM_CH-1:0] burst_exp [0:5];

    initial begin
        n_chk  = 0;
        n_fail = 0;
`ifdef DMEM_ARB_CH0_PRIORITY_EN
        burst_exp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
`else
        burst_exp = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
`endif
        reset        = 1'b1;
        bus.req      = '0;
        bus.lock     = '0;
        bus.wren_ch  = '0;
        bus.addr_ch  = '0;
        bus.wdata_ch = '0;

        // reset holds everything idle even with both channels requesting
        bus.req        = 2'b11;
        bus.addr_ch[0] = 12'h100;
        bus.addr_ch[1] = 12'h200;
        repeat (2) begin
            tick(); #1;
            check("rst_gnt",    bus.gnt,      2'b00);
            check("rst_rvalid", bus.rvalid,   2'b00);
            check("rst_wren",   bus.mem_wren, 1'b0);
            check("rst_addr",   bus.mem_addr, 12'h000);
        end

        // release: ch0 first, then strict alternation
        tick(); reset = 1'b0; #1;
        check("rr0_gnt",  bus.gnt,      2'b01);
        check("rr0_addr", bus.mem_addr, 12'h100);
        tick(); #1;
        check("rr1_gnt",    bus.gnt,      2'b10);
        check("rr1_addr",   bus.mem_addr, 12'h200);
        check("rr1_rvalid", bus.rvalid,   2'b01);
        tick(); #1;
        check("rr2_gnt",    bus.gnt,      2'b01);
        check("rr2_rvalid", bus.rvalid,   2'b10);
        tick(); #1;
        check("rr3_gnt",  bus.gnt,      2'b10);
        check("rr3_addr", bus.mem_addr, 12'h200);
        tick(); bus.req = 2'b00; #1;
        check("idle_gnt",    bus.gnt,      2'b00);
        check("idle_addr",   bus.mem_addr, 12'h000);
        check("idle_rvalid", bus.rvalid,   2'b10);

        // read path: ch1 reads preloaded word
        tick(); bus.req = 2'b10; bus.addr_ch[1] = 12'h010; #1;
        check("rd_gnt",    bus.gnt,      2'b10);
        check("rd_addr",   bus.mem_addr, 12'h010);
        check("rd_rvalid0", bus.rvalid,  2'b00);
        tick(); bus.req = 2'b00; #1;
        check("rd_rvalid1", bus.rvalid, 2'b10);
        check("rd_rdata",   bus.rdata,  32'hDEADBEEF);

        // lock burst by ch1 against a waiting ch0
        for (int i = 0; i < 6; i++) begin
            tick(); bus.req = 2'b11; bus.lock = 2'b10; #1;
            check($sformatf("burst%0d_gnt", i), bus.gnt, burst_exp[i]);
        end
        tick(); bus.req = 2'b00; bus.lock = 2'b00; #1;
        check("burst_idle", bus.gnt, 2'b00);

        // write then read of the same address on consecutive cycles
        tick();
        bus.req = 2'b01; bus.wren_ch = 2'b01;
        bus.addr_ch[0] = 12'h020; bus.wdata_ch[0] = 32'h00000005;
        #1;
        check("wr_gnt",  bus.gnt,      2'b01);
        check("wr_wren", bus.mem_wren, 1'b1);
        check("wr_addr", bus.mem_addr, 12'h020);
        check("wr_data", bus.mem_data, 32'h00000005);
        tick();
        bus.req = 2'b10; bus.wren_ch = 2'b00; bus.addr_ch[1] = 12'h020;
        #1;
        check("wr_rd_gnt",    bus.gnt,      2'b10);
        check("wr_rd_wren",   bus.mem_wren, 1'b0);
        check("wr_no_rvalid", bus.rvalid,   2'b00);
        tick(); bus.req = 2'b00; #1;
        check("wr_rd_rvalid", bus.rvalid, 2'b10);
        check("wr_rd_rdata",  bus.rdata,  32'h00000005);

        // reset right after a granted read drops the return and the pointer
        tick(); bus.req = 2'b01; bus.addr_ch[0] = 12'h010; #1;
        check("rm_gnt", bus.gnt, 2'b01);
        tick(); reset = 1'b1; bus.req = 2'b11; #1;
        check("rm_rvalid", bus.rvalid,   2'b00);
        check("rm_gnt0",   bus.gnt,      2'b00);
        check("rm_wren",   bus.mem_wren, 1'b0);
        tick(); reset = 1'b0; #1;
        check("rm_ptr_gnt", bus.gnt,    2'b01);
        check("rm_rvalid2", bus.rvalid, 2'b00);

        // sole locked requester keeps the port past the burst limit
        for (int i = 0; i < 6; i++) begin
            tick(); bus.req = 2'b10; bus.lock = 2'b10; #1;
            check($sformatf("sole%0d_gnt", i), bus.gnt, 2'b10);
        end
        tick(); bus.req = 2'b00; bus.lock = 2'b00; #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
